// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared FSM state type and select-width helper for the pipelined mux
package mux_pkg;

    // Occupancy of the main + skid register pair
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } mux_state_e;

    // Bits needed to address n channels; never less than one bit
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_sel_n.sv
// rtl/mux_sel_n.sv - combinational N-way channel select with out-of-range flag
module mux_sel_n
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [WIDTH-1:0]        sel_data,
    output logic                    sel_err
);

    // Pick the addressed channel; an out-of-range select matches nothing and yields zero
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // One extra bit so NUM_IN itself is representable when NUM_IN == 2**SEL_W
    assign sel_err = ({1'b0, in_sel} >= (SEL_W+1)'(NUM_IN));

endmodule

// File: rtl/mux_pipe_n.sv
// rtl/mux_pipe_n.sv - one-cycle registered N-way mux with skid buffer and valid/ready handshakes
module mux_pipe_n
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    mux_state_e       state_q;
    logic             in_ready_q;
    logic [WIDTH-1:0] main_data_q;
    logic             main_err_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             skid_err_q;

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic             accept;
    logic             drain;

    mux_sel_n #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_sel (
        .in_data  (in_data),
        .in_sel   (in_sel),
        .sel_data (sel_data),
        .sel_err  (sel_err)
    );

    // in_ready_q is low in TWO, so nothing is accepted (or sampled) while full
    assign accept = in_valid && in_ready_q;
    assign drain  = (state_q != EMPTY) && out_ready;

    // Occupancy FSM; in_ready_q tracks the next state so it never depends on out_ready combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b0;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        main_data_q <= sel_data;
                        main_err_q  <= sel_err;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    in_ready_q <= 1'b1;
                    if (accept && !drain) begin
                        skid_data_q <= sel_data;
                        skid_err_q  <= sel_err;
                        state_q     <= TWO;
                        in_ready_q  <= 1'b0;
                    end else if (accept && drain) begin
                        main_data_q <= sel_data;
                        main_err_q  <= sel_err;
                    end else if (drain) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        main_data_q <= skid_data_q;
                        main_err_q  <= skid_err_q;
                        state_q     <= ONE;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign out_err   = main_err_q;

endmodule

// File: tb/tb_mux_pipe_n.sv
// tb/tb_mux_pipe_n.sv - self-checking bench for mux_pipe_n
module tb_mux_pipe_n;

    logic clk;
    logic rst_n;

    // Instance A: WIDTH=32, NUM_IN=4
    logic [127:0] a_in_data;
    logic [1:0]   a_in_sel;
    logic         a_in_valid, a_in_ready;
    logic [31:0]  a_out_data;
    logic         a_out_err, a_out_valid, a_out_ready;

    // Instance B: WIDTH=32, NUM_IN=3, SEL_W=2
    logic [95:0]  b_in_data;
    logic [1:0]   b_in_sel;
    logic         b_in_valid, b_in_ready;
    logic [31:0]  b_out_data;
    logic         b_out_err, b_out_valid, b_out_ready;

    // Instance C: WIDTH=8, NUM_IN=16
    logic [127:0] c_in_data;
    logic [3:0]   c_in_sel;
    logic         c_in_valid, c_in_ready;
    logic [7:0]   c_out_data;
    logic         c_out_err, c_out_valid, c_out_ready;

    int checks;
    int failures;

    mux_pipe_n #(.WIDTH(32), .NUM_IN(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_sel(a_in_sel), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_err(a_out_err), .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    mux_pipe_n #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_err(b_out_err), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    mux_pipe_n #(.WIDTH(8), .NUM_IN(16)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_data(c_in_data), .in_sel(c_in_sel), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .out_data(c_out_data), .out_err(c_out_err), .out_valid(c_out_valid), .out_ready(c_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {err, value} of an accepted beat, from channel index arithmetic
    function automatic logic [32:0] ref_beat(input logic [511:0] d, input int sel, input int n, input int w);
        logic [511:0] mask;
        logic [511:0] shifted;
        if (sel >= n) return {1'b1, 32'd0};
        mask    = (512'd1 << w) - 512'd1;
        shifted = (d >> (sel * w)) & mask;
        return {1'b0, shifted[31:0]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({a_in_ready, a_out_valid, a_out_err, a_out_data} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%0b vld=%0b err=%0b data=%h expected all zero",
                     a_in_ready, a_out_valid, a_out_err, a_out_data);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_before_edge got=%0b expected=0", a_in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_after_edge got rdy=%0b vld=%0b expected rdy=1 vld=0", a_in_ready, a_out_valid);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        a_in_data   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        a_in_sel    = 2'd2;
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready got=%0b expected=1", a_in_ready);
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'h33333333 || a_out_err !== 1'b0) begin
            failures++;
            $display("FAIL single_beat got vld=%0b data=%h err=%0b expected vld=1 data=33333333 err=0",
                     a_out_valid, a_out_data, a_out_err);
        end
        @(negedge clk); #1;
        checks++;
        if (a_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drained got vld=%0b expected=0", a_out_valid);
        end
    endtask

    task automatic test_illegal_sel();
        logic [32:0] e;
        @(negedge clk);
        b_in_data   = rand128()[95:0];
        b_in_sel    = 2'd3;
        b_in_valid  = 1'b1;
        b_out_ready = 1'b1;
        #1;
        checks++;
        if (b_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL illegal_ready got=%0b expected=1", b_in_ready);
        end
        @(negedge clk);
        e = ref_beat({416'd0, b_in_data}, 1, 3, 32);
        b_in_sel = 2'd1;
        #1;
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== 32'd0 || b_out_err !== 1'b1) begin
            failures++;
            $display("FAIL illegal_beat got vld=%0b data=%h err=%0b expected vld=1 data=0 err=1",
                     b_out_valid, b_out_data, b_out_err);
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        #1;
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== e[31:0] || b_out_err !== e[32]) begin
            failures++;
            $display("FAIL legal_after_illegal got vld=%0b data=%h err=%0b expected vld=1 data=%h err=%0b",
                     b_out_valid, b_out_data, b_out_err, e[31:0], e[32]);
        end
        @(negedge clk); #1;
        checks++;
        if (b_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL illegal_drained got vld=%0b expected=0", b_out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] v[3];
        int           s[3];
        logic [32:0]  e[3];
        for (int i = 0; i < 3; i++) begin
            v[i] = rand128();
            s[i] = $urandom_range(0, 3);
            e[i] = ref_beat({384'd0, v[i]}, s[i], 4, 32);
        end
        for (int cyc = 0; cyc < 8; cyc++) begin
            logic        exp_rdy;
            logic        exp_vld;
            logic [32:0] exp_beat;
            @(negedge clk);
            // offer V0,V1 then hold V2 until it is taken at cycle 5; out_ready rises at cycle 4
            a_in_valid  = (cyc <= 5);
            a_in_data   = v[(cyc < 2) ? cyc : 2];
            a_in_sel    = 2'(s[(cyc < 2) ? cyc : 2]);
            a_out_ready = (cyc >= 4);
            exp_rdy  = !(cyc == 2 || cyc == 3 || cyc == 4);
            exp_vld  = (cyc >= 1 && cyc <= 6);
            exp_beat = (cyc <= 4) ? e[0] : (cyc == 5) ? e[1] : e[2];
            #1;
            checks++;
            if (a_in_ready !== exp_rdy) begin
                failures++;
                $display("FAIL bp_ready cyc=%0d got=%0b expected=%0b", cyc, a_in_ready, exp_rdy);
            end
            checks++;
            if (a_out_valid !== exp_vld) begin
                failures++;
                $display("FAIL bp_valid cyc=%0d got=%0b expected=%0b", cyc, a_out_valid, exp_vld);
            end
            if (exp_vld) begin
                checks++;
                if (a_out_data !== exp_beat[31:0] || a_out_err !== exp_beat[32]) begin
                    failures++;
                    $display("FAIL bp_data cyc=%0d got=%h/%0b expected=%h/%0b",
                             cyc, a_out_data, a_out_err, exp_beat[31:0], exp_beat[32]);
                end
            end
        end
    endtask

    task automatic test_streaming();
        logic [32:0] q[$];
        for (int cyc = 0; cyc <= 101; cyc++) begin
            @(negedge clk);
            a_in_valid  = (cyc < 100);
            a_in_data   = rand128();
            a_in_sel    = 2'($urandom_range(0, 3));
            a_out_ready = 1'b1;
            #1;
            if (cyc < 100) begin
                checks++;
                if (a_in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_ready cyc=%0d got=%0b expected=1", cyc, a_in_ready);
                end
            end
            checks++;
            if (a_out_valid !== (cyc >= 1 && cyc <= 100)) begin
                failures++;
                $display("FAIL stream_valid cyc=%0d got=%0b expected=%0b", cyc, a_out_valid, (cyc >= 1 && cyc <= 100));
            end
            if (a_out_valid && q.size() > 0) begin
                logic [32:0] e;
                e = q.pop_front();
                checks++;
                if (a_out_data !== e[31:0] || a_out_err !== e[32]) begin
                    failures++;
                    $display("FAIL stream_data cyc=%0d got=%h/%0b expected=%h/%0b", cyc, a_out_data, a_out_err, e[31:0], e[32]);
                end
            end
            if (a_in_valid && a_in_ready) q.push_back(ref_beat({384'd0, a_in_data}, int'(a_in_sel), 4, 32));
        end
        a_in_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [32:0] q[$];
        int          sent;
        int          got;
        int          cyc;
        logic        prev_stall;
        logic [7:0]  prev_data;
        sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
        while (got < 10000 && cyc < 60000) begin
            @(negedge clk);
            c_in_valid  = (sent < 10000) && ($urandom_range(0, 9) < 7);
            c_in_data   = rand128();
            c_in_sel    = 4'($urandom_range(0, 15));
            c_out_ready = ($urandom_range(0, 9) < 7);
            #1;
            checks++;
            if (c_in_ready !== (q.size() < 2)) begin
                failures++;
                $display("FAIL rand_ready cyc=%0d got=%0b expected=%0b", cyc, c_in_ready, (q.size() < 2));
            end
            checks++;
            if (c_out_valid !== (q.size() > 0)) begin
                failures++;
                $display("FAIL rand_valid cyc=%0d got=%0b expected=%0b", cyc, c_out_valid, (q.size() > 0));
            end
            if (prev_stall) begin
                checks++;
                if (c_out_data !== prev_data) begin
                    failures++;
                    $display("FAIL rand_stall_stable cyc=%0d got=%h expected=%h", cyc, c_out_data, prev_data);
                end
            end
            if (c_out_valid && c_out_ready && q.size() > 0) begin
                logic [32:0] e;
                e = q.pop_front();
                got++;
                checks++;
                if (c_out_data !== e[7:0] || c_out_err !== e[32]) begin
                    failures++;
                    $display("FAIL rand_data beat=%0d got=%h/%0b expected=%h/%0b", got, c_out_data, c_out_err, e[7:0], e[32]);
                end
            end
            if (c_in_valid && c_in_ready) begin
                q.push_back(ref_beat({384'd0, c_in_data}, int'(c_in_sel), 16, 8));
                sent++;
            end
            prev_stall = c_out_valid && !c_out_ready;
            prev_data  = c_out_data;
            cyc++;
        end
        c_in_valid = 1'b0;
        checks++;
        if (got != 10000) begin
            failures++;
            $display("FAIL rand_timeout got=%0d beats expected=10000", got);
        end
    endtask

    task automatic test_reset_two();
        @(negedge clk);
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = rand128();
        a_in_sel    = 2'd1;
        @(negedge clk);
        a_in_data   = rand128();
        @(negedge clk);
        a_in_valid  = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst2_full got vld=%0b rdy=%0b expected vld=1 rdy=0", a_out_valid, a_in_ready);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_in_ready, a_out_valid, a_out_err, a_out_data} !== 35'd0) begin
            failures++;
            $display("FAIL rst2_async got rdy=%0b vld=%0b err=%0b data=%h expected all zero",
                     a_in_ready, a_out_valid, a_out_err, a_out_data);
        end
        @(negedge clk);
        a_out_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst2_release got rdy=%0b vld=%0b expected rdy=0 vld=0", a_in_ready, a_out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst2_after cyc=%0d got rdy=%0b vld=%0b expected rdy=1 vld=0", i, a_in_ready, a_out_valid);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        a_in_data = '0; a_in_sel = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        b_in_data = '0; b_in_sel = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        c_in_data = '0; c_in_sel = '0; c_in_valid = 1'b0; c_out_ready = 1'b0;
        test_reset();
        test_single();
        test_illegal_sel();
        test_backpressure();
        test_streaming();
        test_random();
        test_reset_two();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
